lif_array: RTL and testbench
============================

Name: lif_array

Overview:
- Time-multiplexed bank of NUM_NEURONS adaptive-threshold leaky integrate-and-fire neurons. It is the parametrised successor of the single 8-bit LIF cell.
- Adds configurable width, leak shift, saturating arithmetic, threshold ceiling and floor, a refractory period, and a sweep handshake.
- On each tick_i it updates every neuron once, one neuron per clock, using one shared datapath. It then publishes the spike vector to the downstream spike encoder/router.

Parameters:
- NUM_NEURONS, 4, neuron count, >=1.
- WIDTH, 8, bit width of membrane state, current and threshold.
- THRESHOLD, 128, threshold value at reset.
- THRESHOLD_INC, 5, threshold increase on spike (saturating at 2^WIDTH-1).
- THRESHOLD_DEC, 1, threshold decrease on a non-spiking update.
- THRESHOLD_MIN, 75, floor for the threshold decay.
- LEAK_SHIFT, 1, membrane decay is state >> LEAK_SHIFT.
- REFRACT, 2, number of ticks a neuron is inactive after it spikes (0 = none).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- tick_i  in  1  starts a sweep (single-cycle strobe).
- current_i  in  NUM_NEURONS*WIDTH  per-neuron input current; neuron k uses bits [k*WIDTH +: WIDTH].
- busy_o  out  1  high while a sweep is in progress.
- done_o  out  1  one-cycle pulse when spikes_o is updated.
- spikes_o  out  NUM_NEURONS  spike vector from the last completed sweep.
- overrun_o  out  1  one-cycle pulse when tick_i arrives while busy.
- probe_sel_i  in  max(1,$clog2(NUM_NEURONS))  selects the neuron shown on the probe outputs.
- probe_state_o  out  WIDTH  membrane state of the selected neuron (combinational read).
- probe_thr_o  out  WIDTH  threshold of the selected neuron (combinational read).

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is asynchronous and active-high.
- Reset values:
  - all membrane states 0, all thresholds THRESHOLD, all refractory counters 0;
  - spikes_o 0, busy_o 0, done_o 0, overrun_o 0;
  - FSM in IDLE, neuron index 0.
- FSM states: IDLE, SWEEP, DONE.
- IDLE:
  - tick_i=1 latches current_i into a snapshot register, sets index 0, and moves to SWEEP.
  - busy_o rises on the next cycle.
- SWEEP:
  - Each cycle updates neuron[index] from the snapshot; index increments.
  - After index NUM_NEURONS-1 the FSM moves to DONE.
  - The sweep lasts exactly NUM_NEURONS cycles.
- DONE:
  - spikes_o is loaded from a shadow register, done_o=1 for this single cycle, busy_o=0.
  - The FSM returns to IDLE.
- Latency: tick_i sampled at edge t gives done_o high during the cycle after edge t+NUM_NEURONS+1.
- spikes_o holds its value until the next DONE.
- Ticks while busy:
  - tick_i in SWEEP or DONE is ignored and overrun_o pulses for one cycle.
  - No queued sweep is started.
- Per-neuron update (all arithmetic is unsigned, WIDTH bits, saturating):
  - Refractory (refr>0): refr-1; state 0; spike 0; threshold decays.
  - Active (refr==0): v = sat(cur + (state >> LEAK_SHIFT)).
    - If v >= thr: spike 1; state 0; thr = sat(thr + THRESHOLD_INC); refr = REFRACT.
    - Otherwise: spike 0; state v; threshold decays.
  - Threshold decay: thr = max(thr - THRESHOLD_DEC, THRESHOLD_MIN) if thr > THRESHOLD_MIN; otherwise unchanged.
  - A threshold raised above the ceiling saturates at 2^WIDTH-1.
  - The threshold compare uses the threshold value from before this update.
- Refractory counter width: max(1, $clog2(REFRACT+1)).
- Reset mid-sweep aborts immediately: all state returns to reset values and no done_o is produced.
- The probe outputs read live storage, including values updated during a sweep.

Decomposition:
- Package lif_pkg holds:
  - the FSM state enum (IDLE/SWEEP/DONE);
  - the saturating-add and floor-subtract helper functions;
  - the refractory-width localparam expression.
- Sub-module lif_update: a combinational single-neuron datapath.
  - Inputs: cur, state, thr, refr. Outputs: next state, next thr, next refr, spike.
  - It is instantiated once, with the neuron storage arrays in lif_array.

Test Plan (all defaults unless stated):
1. Integration and refractory:
   - Stimulus: neuron 0 current 100, one tick per sweep.
   - Sweep 1: state 100, thr 127, spike 0.
   - Sweep 2: v=150 gives spike 1, state 0, thr 132.
   - Sweeps 3-4: spike 0, thr 131 then 130.
   - Sweep 5: state 100, thr 129.
2. Latency and handshake:
   - Stimulus: NUM_NEURONS=4, tick at edge t.
   - Response: busy_o high 4 cycles, done_o a single pulse on the cycle after edge t+5, spikes_o changes only then.
3. Overrun:
   - Stimulus: second tick_i 2 cycles after the first.
   - Response: overrun_o pulses once, exactly one done_o, no second sweep until the next IDLE tick.
4. Saturation:
   - Stimulus: REFRACT=0, current 255 every sweep.
   - Response: spike every sweep; thr = 128+5k, saturates at 255 from sweep 26; spikes continue (255 >= 255).
5. Floor:
   - Stimulus: current 0 for 60 sweeps.
   - Response: probe_thr_o reaches 75 at sweep 53 and stays 75; spikes 0.
6. Mid-sweep reset:
   - Stimulus: rst_i asserted during sweep cycle 2, asynchronous to the clock edge.
   - Response: busy_o, spikes_o and probe_state_o go to 0 and probe_thr_o to 128 without waiting for a clock edge; no done_o follows.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared types and arithmetic helpers for the time-multiplexed LIF neuron bank.
package lif_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } lif_state_e;

  // Refractory counter must hold REFRACT; keep at least one bit when REFRACT is 0.
  function automatic int refr_width(input int refract);
    return (refract < 1) ? 1 : $clog2(refract + 1);
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
  endfunction

  function automatic logic [31:0] floor_sub(input logic [31:0] a,
                                            input logic [31:0] dec,
                                            input logic [31:0] floor_val);
    if (a <= floor_val) return a;
    return ((a - floor_val) >= dec) ? (a - dec) : floor_val;
  endfunction

endpackage

// File: rtl/lif_if.sv
// Sweep handshake, current bus, spike vector and probe port of the LIF neuron bank.
interface lif_if #(
  parameter int NUM_NEURONS = 4,
  parameter int WIDTH       = 8
);
  localparam int SELW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  logic                         tick_i;
  logic [NUM_NEURONS*WIDTH-1:0] current_i;
  logic [SELW-1:0]              probe_sel_i;
  logic                         busy_o;
  logic                         done_o;
  logic                         overrun_o;
  logic [NUM_NEURONS-1:0]       spikes_o;
  logic [WIDTH-1:0]             probe_state_o;
  logic [WIDTH-1:0]             probe_thr_o;

  modport master (
    output tick_i, current_i, probe_sel_i,
    input  busy_o, done_o, overrun_o, spikes_o, probe_state_o, probe_thr_o
  );

  modport slave (
    input  tick_i, current_i, probe_sel_i,
    output busy_o, done_o, overrun_o, spikes_o, probe_state_o, probe_thr_o
  );
endinterface

// File: rtl/lif_update.sv
// Combinational single-neuron update: leak, integrate, fire, adaptive threshold and refractory.
module lif_update
  import lif_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int THRESHOLD_INC = 5,
  parameter int THRESHOLD_DEC = 1,
  parameter int THRESHOLD_MIN = 75,
  parameter int LEAK_SHIFT    = 1,
  parameter int REFRACT       = 2,
  parameter int RW            = refr_width(REFRACT)
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] state,
  input  logic [WIDTH-1:0] thr,
  input  logic [RW-1:0]    refr,
  output logic [WIDTH-1:0] state_nxt,
  output logic [WIDTH-1:0] thr_nxt,
  output logic [RW-1:0]    refr_nxt,
  output logic             spike
);

  localparam logic [31:0] MAX_VAL = (32'd1 << WIDTH) - 32'd1;

  logic [WIDTH-1:0] v;
  logic [WIDTH-1:0] thr_up;
  logic [WIDTH-1:0] thr_decay;

  always_comb begin
    // Saturated results never exceed MAX_VAL, so narrowing back to WIDTH is lossless.
    v         = WIDTH'(sat_add(32'(cur), 32'(state >> LEAK_SHIFT), MAX_VAL));
    thr_up    = WIDTH'(sat_add(32'(thr), 32'(THRESHOLD_INC), MAX_VAL));
    thr_decay = WIDTH'(floor_sub(32'(thr), 32'(THRESHOLD_DEC), 32'(THRESHOLD_MIN)));

    // NOTE: every output gets a default before any branch, so no path can infer a latch.
    state_nxt = state;
    thr_nxt   = thr_decay;
    refr_nxt  = refr;
    spike     = 1'b0;

    if (refr != '0) begin
      refr_nxt  = refr - RW'(1);
      state_nxt = '0;
    end else if (v >= thr) begin
      spike     = 1'b1;
      state_nxt = '0;
      thr_nxt   = thr_up;
      refr_nxt  = RW'(REFRACT);
    end else begin
      state_nxt = v;
    end
  end

endmodule

// File: rtl/lif_array.sv
// Bank of NUM_NEURONS adaptive-threshold LIF neurons sharing one datapath, one neuron per clock.
module lif_array
  import lif_pkg::*;
#(
  parameter int NUM_NEURONS   = 4,
  parameter int WIDTH         = 8,
  parameter int THRESHOLD     = 128,
  parameter int THRESHOLD_INC = 5,
  parameter int THRESHOLD_DEC = 1,
  parameter int THRESHOLD_MIN = 75,
  parameter int LEAK_SHIFT    = 1,
  parameter int REFRACT       = 2
) (
  input logic   clk_i,
  input logic   rst_i,
  lif_if.slave  bus
);

  localparam int IDXW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int RW   = refr_width(REFRACT);

  lif_state_e             state_q, state_d;
  logic [IDXW-1:0]        idx_q;
  logic                   last_idx;
  logic [WIDTH-1:0]       snap_q    [NUM_NEURONS];
  logic [WIDTH-1:0]       state_mem [NUM_NEURONS];
  logic [WIDTH-1:0]       thr_mem   [NUM_NEURONS];
  logic [RW-1:0]          refr_mem  [NUM_NEURONS];
  logic [NUM_NEURONS-1:0] shadow_q;
  logic [NUM_NEURONS-1:0] spikes_q;
  logic                   done_q;
  logic                   overrun_q;

  logic [WIDTH-1:0]       upd_state;
  logic [WIDTH-1:0]       upd_thr;
  logic [RW-1:0]          upd_refr;
  logic                   upd_spike;

  assign last_idx = (idx_q == IDXW'(NUM_NEURONS - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.tick_i) state_d = SWEEP;
      SWEEP:   if (last_idx)   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  lif_update #(
    .WIDTH         (WIDTH),
    .THRESHOLD_INC (THRESHOLD_INC),
    .THRESHOLD_DEC (THRESHOLD_DEC),
    .THRESHOLD_MIN (THRESHOLD_MIN),
    .LEAK_SHIFT    (LEAK_SHIFT),
    .REFRACT       (REFRACT),
    .RW            (RW)
  ) u_update (
    .cur       (snap_q[idx_q]),
    .state     (state_mem[idx_q]),
    .thr       (thr_mem[idx_q]),
    .refr      (refr_mem[idx_q]),
    .state_nxt (upd_state),
    .thr_nxt   (upd_thr),
    .refr_nxt  (upd_refr),
    .spike     (upd_spike)
  );

  // NOTE: the neuron storage is a register file, not a RAM, so it takes the async reset
  // like any other flop; a mid-sweep reset must restore every neuron at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q     <= '0;
      shadow_q  <= '0;
      spikes_q  <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      for (int k = 0; k < NUM_NEURONS; k++) begin
        snap_q[k]    <= '0;
        state_mem[k] <= '0;
        thr_mem[k]   <= WIDTH'(THRESHOLD);
        refr_mem[k]  <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      done_q    <= (state_q == DONE);
      overrun_q <= bus.tick_i && (state_q != IDLE);
      unique case (state_q)
        IDLE: begin
          if (bus.tick_i) begin
            idx_q <= '0;
            for (int k = 0; k < NUM_NEURONS; k++) begin
              snap_q[k] <= bus.current_i[k*WIDTH +: WIDTH];
            end
          end
        end
        SWEEP: begin
          state_mem[idx_q] <= upd_state;
          thr_mem[idx_q]   <= upd_thr;
          refr_mem[idx_q]  <= upd_refr;
          shadow_q[idx_q]  <= upd_spike;
          idx_q            <= last_idx ? '0 : idx_q + IDXW'(1);
        end
        DONE:    spikes_q <= shadow_q;
        default: ;
      endcase
    end
  end

  assign bus.busy_o    = (state_q == SWEEP);
  assign bus.done_o    = done_q;
  assign bus.overrun_o = overrun_q;
  assign bus.spikes_o  = spikes_q;

  // Probe reads live storage; selections past the last neuron read as zero.
  always_comb begin
    bus.probe_state_o = '0;
    bus.probe_thr_o   = '0;
    if (int'(bus.probe_sel_i) < NUM_NEURONS) begin
      bus.probe_state_o = state_mem[bus.probe_sel_i];
      bus.probe_thr_o   = thr_mem[bus.probe_sel_i];
    end
  end

endmodule

// File: tb/tb_lif_array.sv
// Directed scoreboard bench for lif_array: default instance plus a REFRACT=0 instance for saturation.
module tb_lif_array;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int REFR = 2;
  localparam int THR0 = 128;
  localparam int INC  = 5;
  localparam int DEC  = 1;
  localparam int TMIN = 75;
  localparam int MAXV = 255;

  typedef struct packed {
    logic [N-1:0]   spikes;
    logic [N*W-1:0] st;
    logic [N*W-1:0] th;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  lif_if #(.NUM_NEURONS(N), .WIDTH(W)) ifc ();
  lif_if #(.NUM_NEURONS(N), .WIDTH(W)) ifc_r0 ();

  lif_array #(
    .NUM_NEURONS(N), .WIDTH(W), .THRESHOLD(THR0), .THRESHOLD_INC(INC), .THRESHOLD_DEC(DEC),
    .THRESHOLD_MIN(TMIN), .LEAK_SHIFT(1), .REFRACT(REFR)
  ) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(ifc.slave));

  lif_array #(
    .NUM_NEURONS(N), .WIDTH(W), .THRESHOLD(THR0), .THRESHOLD_INC(INC), .THRESHOLD_DEC(DEC),
    .THRESHOLD_MIN(TMIN), .LEAK_SHIFT(1), .REFRACT(0)
  ) dut_r0 (.clk_i(clk_i), .rst_i(rst_i), .bus(ifc_r0.slave));

  exp_t         sb_q[$];
  exp_t         sb_r0_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           m_state[N];
  int           m_thr[N];
  int           m_refr[N];
  logic [N-1:0] last_spikes;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_state[k] = 0;
      m_thr[k]   = THR0;
      m_refr[k]  = 0;
    end
    last_spikes = '0;
  endtask

  function automatic int decayed(input int t);
    if (t <= TMIN) return t;
    return (t - DEC < TMIN) ? TMIN : t - DEC;
  endfunction

  // Reference model of one sweep; pushes the expected post-sweep image to the scoreboard.
  task automatic model_sweep(input logic [N*W-1:0] cur);
    exp_t e;
    int   c;
    int   v;
    e = '0;
    for (int k = 0; k < N; k++) begin
      c = int'(cur[k*W +: W]);
      if (m_refr[k] > 0) begin
        m_refr[k]  = m_refr[k] - 1;
        m_state[k] = 0;
        m_thr[k]   = decayed(m_thr[k]);
      end else begin
        v = c + (m_state[k] / 2);
        if (v > MAXV) v = MAXV;
        if (v >= m_thr[k]) begin
          e.spikes[k] = 1'b1;
          m_state[k]  = 0;
          m_thr[k]    = (m_thr[k] + INC > MAXV) ? MAXV : m_thr[k] + INC;
          m_refr[k]   = REFR;
        end else begin
          m_state[k] = v;
          m_thr[k]   = decayed(m_thr[k]);
        end
      end
      e.st[k*W +: W] = W'(m_state[k]);
      e.th[k*W +: W] = W'(m_thr[k]);
    end
    sb_q.push_back(e);
  endtask

  task automatic wait_done(input string tag, input bit r0);
    int n = 0;
    while (n < 20 && !(r0 ? ifc_r0.done_o : ifc.done_o)) begin
      @(negedge clk_i);
      n++;
    end
    check({tag, "_done_seen"}, r0 ? ifc_r0.done_o : ifc.done_o, 1);
  endtask

  task automatic compare_main(input string tag);
    exp_t e;
    check({tag, "_sb_depth"}, sb_q.size(), 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, "_spikes"}, ifc.spikes_o, e.spikes);
      last_spikes = e.spikes;
      for (int k = 0; k < N; k++) begin
        ifc.probe_sel_i = 2'(k);
        #1;
        check($sformatf("%s_state%0d", tag, k), ifc.probe_state_o, e.st[k*W +: W]);
        check($sformatf("%s_thr%0d", tag, k), ifc.probe_thr_o, e.th[k*W +: W]);
      end
    end
  endtask

  task automatic run_sweep(input string tag, input logic [N*W-1:0] cur);
    model_sweep(cur);
    @(negedge clk_i);
    ifc.current_i = cur;
    ifc.tick_i    = 1'b1;
    @(negedge clk_i);
    ifc.tick_i = 1'b0;
    wait_done(tag, 1'b0);
    compare_main(tag);
  endtask

  // REFRACT=0 instance: neuron 0 driven at full scale fires every sweep, others idle at 0.
  task automatic run_sweep_r0(input int s);
    exp_t  e;
    string tag;
    tag      = $sformatf("sat%0d", s);
    e        = '0;
    e.spikes = 4'b0001;
    e.th[0 +: W] = W'((THR0 + INC * s > MAXV) ? MAXV : THR0 + INC * s);
    for (int k = 1; k < N; k++) e.th[k*W +: W] = W'((THR0 - s < TMIN) ? TMIN : THR0 - s);
    sb_r0_q.push_back(e);
    @(negedge clk_i);
    ifc_r0.current_i = {8'd0, 8'd0, 8'd0, 8'd255};
    ifc_r0.tick_i    = 1'b1;
    @(negedge clk_i);
    ifc_r0.tick_i = 1'b0;
    wait_done(tag, 1'b1);
    check({tag, "_sb_depth"}, sb_r0_q.size(), 1);
    if (sb_r0_q.size() > 0) begin
      e = sb_r0_q.pop_front();
      check({tag, "_spikes"}, ifc_r0.spikes_o, e.spikes);
      for (int k = 0; k < N; k++) begin
        ifc_r0.probe_sel_i = 2'(k);
        #1;
        check($sformatf("%s_state%0d", tag, k), ifc_r0.probe_state_o, e.st[k*W +: W]);
        check($sformatf("%s_thr%0d", tag, k), ifc_r0.probe_thr_o, e.th[k*W +: W]);
      end
    end
  endtask

  localparam logic [N*W-1:0] CUR1 = {8'd37, 8'd200, 8'd0, 8'd100};
  localparam logic [N*W-1:0] CUR2 = {8'd255, 8'd255, 8'd255, 8'd255};
  localparam logic [N*W-1:0] CUR3 = {8'd30, 8'd60, 8'd90, 8'd120};
  localparam logic [N*W-1:0] CUR6 = {8'd0, 8'd0, 8'd50, 8'd200};

  initial begin
    int exp_st1[5];
    int exp_th1[5];
    int exp_sp1[5];
    int n_ovr;
    int n_done;
    exp_st1 = '{100, 0, 0, 0, 100};
    exp_th1 = '{127, 132, 131, 130, 129};
    exp_sp1 = '{0, 1, 0, 0, 0};

    rst_i = 1'b1;
    ifc.tick_i = 1'b0;      ifc.current_i = '0;    ifc.probe_sel_i = '0;
    ifc_r0.tick_i = 1'b0;   ifc_r0.current_i = '0; ifc_r0.probe_sel_i = '0;
    model_reset();
    #1;
    check("rst_busy", ifc.busy_o, 0);
    check("rst_done", ifc.done_o, 0);
    check("rst_overrun", ifc.overrun_o, 0);
    check("rst_spikes", ifc.spikes_o, 0);
    for (int k = 0; k < N; k++) begin
      ifc.probe_sel_i = 2'(k);
      #1;
      check($sformatf("rst_state%0d", k), ifc.probe_state_o, 0);
      check($sformatf("rst_thr%0d", k), ifc.probe_thr_o, THR0);
    end
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Integration, firing and refractory on neuron 0 with known per-sweep values.
    for (int s = 0; s < 5; s++) begin
      run_sweep($sformatf("int%0d", s + 1), CUR1);
      @(negedge clk_i);
      ifc.probe_sel_i = '0;
      #1;
      check($sformatf("int%0d_n0_state", s + 1), ifc.probe_state_o, exp_st1[s]);
      check($sformatf("int%0d_n0_thr", s + 1), ifc.probe_thr_o, exp_th1[s]);
      check($sformatf("int%0d_n0_spike", s + 1), ifc.spikes_o[0], exp_sp1[s]);
    end

    // Latency: busy for four cycles, done and the new spike vector one cycle after DONE.
    model_sweep(CUR2);
    @(negedge clk_i);
    ifc.current_i = CUR2;
    ifc.tick_i    = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk_i);
      if (k == 1) ifc.tick_i = 1'b0;
      check($sformatf("lat_busy_k%0d", k), ifc.busy_o, (k <= 4));
      check($sformatf("lat_done_k%0d", k), ifc.done_o, (k == 6));
      if (k < 6) check($sformatf("lat_hold_k%0d", k), ifc.spikes_o, last_spikes);
      if (k == 6) compare_main("lat");
    end

    // Overrun: a second tick two cycles into the sweep is flagged and dropped.
    n_ovr  = 0;
    n_done = 0;
    model_sweep(CUR3);
    @(negedge clk_i);
    ifc.current_i = CUR3;
    ifc.tick_i    = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk_i);
      if (k == 1 || k == 3) ifc.tick_i = 1'b0;
      n_ovr  += int'(ifc.overrun_o);
      n_done += int'(ifc.done_o);
      check($sformatf("ovr_pulse_k%0d", k), ifc.overrun_o, (k == 3));
      check($sformatf("ovr_busy_k%0d", k), ifc.busy_o, (k <= 4));
      if (k == 6) compare_main("ovr");
      if (k == 2) ifc.tick_i = 1'b1;
    end
    check("ovr_count", n_ovr, 1);
    check("ovr_done_count", n_done, 1);

    // Saturation on the REFRACT=0 instance: threshold climbs by 5 and pins at 255.
    for (int s = 1; s <= 30; s++) run_sweep_r0(s);

    // Floor: from reset, zero input decays every threshold to 75 by sweep 53.
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();
    for (int s = 1; s <= 60; s++) begin
      run_sweep($sformatf("floor%0d", s), '0);
      if (s == 52 || s == 53 || s == 60) begin
        @(negedge clk_i);
        ifc.probe_sel_i = '0;
        #1;
        check($sformatf("floor%0d_n0_thr", s), ifc.probe_thr_o, (s == 52) ? 76 : TMIN);
      end
    end

    // Mid-sweep reset: outputs and storage clear immediately, no done follows.
    run_sweep("pre_rst", CUR6);
    @(negedge clk_i);
    ifc.current_i = CUR6;
    ifc.tick_i    = 1'b1;
    @(negedge clk_i);
    ifc.tick_i      = 1'b0;
    ifc.probe_sel_i = 2'd1;
    @(posedge clk_i);
    #2;
    check("mid_busy_before", ifc.busy_o, 1);
    check("mid_state1_before", ifc.probe_state_o, 50);
    rst_i = 1'b1;
    #1;
    check("mid_busy", ifc.busy_o, 0);
    check("mid_spikes", ifc.spikes_o, 0);
    check("mid_state1", ifc.probe_state_o, 0);
    check("mid_thr1", ifc.probe_thr_o, THR0);
    ifc.probe_sel_i = 2'd0;
    #1;
    check("mid_thr0", ifc.probe_thr_o, THR0);
    @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk_i);
      check($sformatf("mid_no_done_k%0d", k), ifc.done_o, 0);
      check($sformatf("mid_idle_k%0d", k), ifc.busy_o, 0);
    end
    run_sweep("post_rst", CUR1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
